// File: rtl/class_hvec_search.sv
// Nearest-class search: buffers a query hypervector, sweeps every class/frame of the class-vector
// source and reports the class with the smallest Hamming distance.
module class_hvec_search #(
    parameter int unsigned DI_PARALLEL_W_BITS = 64,
    parameter int unsigned NUM_CLASSES        = 8,
    parameter int unsigned NUM_FRAMES         = 3,
    parameter int unsigned CLASS_ID_W         = 3,
    parameter int unsigned FRAME_IDX_W        = 2,
    parameter int unsigned DIST_W             = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          q_valid,
    output logic                          q_ready,
    input  logic [DI_PARALLEL_W_BITS-1:0] q_data,
    output logic [CLASS_ID_W-1:0]         frame_id,
    output logic [FRAME_IDX_W-1:0]        frame_index,
    input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [CLASS_ID_W-1:0]         pred_class,
    output logic [DIST_W-1:0]             min_dist,
    output logic                          busy
);

    localparam logic [FRAME_IDX_W-1:0] LastFrm = FRAME_IDX_W'(NUM_FRAMES - 1);
    localparam logic [CLASS_ID_W-1:0]  LastCls = CLASS_ID_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        StLoad,
        StSearch,
        StResult
    } state_e;

    state_e                        state_q, state_d;
    logic [FRAME_IDX_W-1:0]        q_cnt_q, q_cnt_d;
    logic [FRAME_IDX_W-1:0]        frm_q, frm_d;
    logic [CLASS_ID_W-1:0]         cls_q, cls_d;
    logic [DIST_W-1:0]             acc_q, acc_d;
    logic [DIST_W-1:0]             best_dist_q, best_dist_d;
    logic [CLASS_ID_W-1:0]         best_cls_q, best_cls_d;
    logic [DI_PARALLEL_W_BITS-1:0] query_q [NUM_FRAMES];

    logic                          q_fire;
    logic [DI_PARALLEL_W_BITS-1:0] diff;
    logic [DIST_W-1:0]             pc;
    logic [DIST_W-1:0]             total;

    assign q_fire = (state_q == StLoad) && q_valid;

    // Query buffer has no reset: every slot is rewritten before a search can start.
    always_ff @(posedge clk) begin
        if (q_fire) begin
            query_q[q_cnt_q] <= q_data;
        end
    end

    assign diff = query_q[frm_q] ^ class_vec_in;

    always_comb begin
        pc = '0;
        for (int i = 0; i < DI_PARALLEL_W_BITS; i++) begin
            pc = pc + DIST_W'(diff[i]);
        end
    end

    assign total = acc_q + pc;

    always_comb begin
        state_d     = state_q;
        q_cnt_d     = q_cnt_q;
        frm_d       = frm_q;
        cls_d       = cls_q;
        acc_d       = acc_q;
        best_dist_d = best_dist_q;
        best_cls_d  = best_cls_q;

        case (state_q)
            StLoad: begin
                if (q_valid) begin
                    if (q_cnt_q == LastFrm) begin
                        q_cnt_d = '0;
                        state_d = StSearch;
                    end else begin
                        q_cnt_d = q_cnt_q + 1'b1;
                    end
                end
            end
            StSearch: begin
                if (frm_q != LastFrm) begin
                    acc_d = total;
                    frm_d = frm_q + 1'b1;
                end else begin
                    // Strict compare: on a tie the lower class index wins.
                    if (cls_q == '0 || total < best_dist_q) begin
                        best_dist_d = total;
                        best_cls_d  = cls_q;
                    end
                    acc_d = '0;
                    frm_d = '0;
                    if (cls_q == LastCls) begin
                        cls_d   = '0;
                        state_d = StResult;
                    end else begin
                        cls_d = cls_q + 1'b1;
                    end
                end
            end
            StResult: begin
                if (result_ready) begin
                    state_d = StLoad;
                    cls_d   = '0;
                    frm_d   = '0;
                    acc_d   = '0;
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            q_cnt_q     <= '0;
            frm_q       <= '0;
            cls_q       <= '0;
            acc_q       <= '0;
            best_dist_q <= '0;
            best_cls_q  <= '0;
        end else begin
            state_q     <= state_d;
            q_cnt_q     <= q_cnt_d;
            frm_q       <= frm_d;
            cls_q       <= cls_d;
            acc_q       <= acc_d;
            best_dist_q <= best_dist_d;
            best_cls_q  <= best_cls_d;
        end
    end

    assign q_ready      = (state_q == StLoad);
    assign busy         = (state_q == StSearch);
    assign result_valid = (state_q == StResult);
    assign frame_id     = busy ? cls_q : '0;
    assign frame_index  = busy ? frm_q : '0;
    assign pred_class   = best_cls_q;
    assign min_dist     = best_dist_q;

endmodule

// File: tb/tb_class_hvec_search.sv
// Randomized self-checking bench for class_hvec_search with a bench-side class ROM and an
// argmin-of-Hamming-distance reference model.
module tb_class_hvec_search;

    localparam int W  = 64;
    localparam int NC = 8;
    localparam int NF = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          q_valid = 1'b0;
    logic          q_ready;
    logic [W-1:0]  q_data = '0;
    logic [2:0]    frame_id;
    logic [1:0]    frame_index;
    logic [W-1:0]  class_vec_in;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [2:0]    pred_class;
    logic [7:0]    min_dist;
    logic          busy;

    logic [W-1:0]  rom [NC][NF];
    logic [W-1:0]  qry [NF];
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    assign class_vec_in = (frame_index < 2'(NF)) ? rom[frame_id][frame_index] : '0;

    class_hvec_search dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .q_valid      (q_valid),
        .q_ready      (q_ready),
        .q_data       (q_data),
        .frame_id     (frame_id),
        .frame_index  (frame_index),
        .class_vec_in (class_vec_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .pred_class   (pred_class),
        .min_dist     (min_dist),
        .busy         (busy)
    );

    // Reference: argmin over classes of the total Hamming distance, lowest index on ties.
    function automatic void ref_search(output int bc, output int bd);
        bc = 0;
        bd = 1 << 30;
        for (int c = 0; c < NC; c++) begin
            int d = 0;
            for (int f = 0; f < NF; f++) d += $countones(qry[f] ^ rom[c][f]);
            if (d < bd) begin
                bd = d;
                bc = c;
            end
        end
    endfunction

    task automatic do_reset();
        q_valid = 1'b0;
        result_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Sends qry[]; returns at the negedge after the final handshake. hold keeps q_valid high.
    task automatic send_query(input bit hold);
        for (int f = 0; f < NF; f++) begin
            int t = 0;
            @(negedge clk);
            q_valid = 1'b1;
            q_data = qry[f];
            while (!q_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t >= 50) begin
                n_fail++;
                $display("FAIL send_query: q_ready stuck at %0b, required 1", q_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        if (hold) q_data = {$urandom, $urandom};
        else q_valid = 1'b0;
    endtask

    // Observes SEARCH until result_valid (bounded); addr_ok covers address order and q_ready=0.
    task automatic run_search(output int lat, output int bcnt, output bit addr_ok);
        int k = 0;
        lat = 0;
        bcnt = 0;
        addr_ok = 1'b1;
        while (!result_valid && lat < 100) begin
            if (busy) bcnt++;
            if (frame_id !== 3'(k / NF) || frame_index !== 2'(k % NF) || q_ready) addr_ok = 1'b0;
            k++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        q_valid = 1'b0;
    endtask

    task automatic consume(input int delay, output logic qr, output logic rv);
        repeat (delay) @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        qr = q_ready;
        rv = result_valid;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (q_ready !== 1'b1) begin n_fail++; $display("FAIL reset_q_ready: got %0b, required 1", q_ready); end
        n_checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_busy: got %0b/%0b, required 0/0", result_valid, busy);
        end
        n_checks++;
        if (frame_id !== 3'd0 || frame_index !== 2'd0) begin
            n_fail++; $display("FAIL reset_addr: got %0d/%0d, required 0/0", frame_id, frame_index);
        end
        n_checks++;
        if (min_dist !== 8'd0 || pred_class !== 3'd0) begin
            n_fail++; $display("FAIL reset_result: got %0d/%0d, required 0/0", pred_class, min_dist);
        end
    endtask

    task automatic test_zero_class();
        int lat, bcnt;
        bit aok;
        logic qr, rv;
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++) rom[c][f] = (c == 5) ? 64'h0 : '1;
        for (int f = 0; f < NF; f++) qry[f] = 64'h0;
        send_query(1'b0);
        run_search(lat, bcnt, aok);
        n_checks++;
        if (lat !== 24) begin n_fail++; $display("FAIL zero_latency: got %0d, required 24", lat); end
        n_checks++;
        if (!aok) begin n_fail++; $display("FAIL zero_addr_seq: got bad sweep, required class-outer/frame-inner"); end
        n_checks++;
        if (pred_class !== 3'd5 || min_dist !== 8'd0) begin
            n_fail++; $display("FAIL zero_result: got %0d/%0d, required 5/0", pred_class, min_dist);
        end
        consume(0, qr, rv);
        n_checks++;
        if (qr !== 1'b1 || rv !== 1'b0) begin
            n_fail++; $display("FAIL zero_consume: got q_ready=%0b valid=%0b, required 1/0", qr, rv);
        end
    endtask

    task automatic test_unique_match();
        int lat, bcnt;
        bit aok;
        logic qr, rv;
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++) rom[c][f] = (64'h1 << c) - 64'h1;
        for (int f = 0; f < NF; f++) qry[f] = rom[3][f];
        send_query(1'b0);
        run_search(lat, bcnt, aok);
        n_checks++;
        if (pred_class !== 3'd3 || min_dist !== 8'd0) begin
            n_fail++; $display("FAIL match_exact: got %0d/%0d, required 3/0", pred_class, min_dist);
        end
        consume(1, qr, rv);
        qry[0][10] = ~qry[0][10];
        qry[0][20] = ~qry[0][20];
        qry[0][30] = ~qry[0][30];
        qry[1][40] = ~qry[1][40];
        qry[2][50] = ~qry[2][50];
        send_query(1'b0);
        run_search(lat, bcnt, aok);
        n_checks++;
        if (pred_class !== 3'd3 || min_dist !== 8'd5) begin
            n_fail++; $display("FAIL match_flip5: got %0d/%0d, required 3/5", pred_class, min_dist);
        end
        consume(0, qr, rv);
    endtask

    task automatic test_tie();
        int lat, bcnt;
        bit aok;
        logic qr, rv;
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++) rom[c][f] = 64'h0;
        for (int f = 0; f < NF; f++) qry[f] = 64'hFFFF_FFFF_FFFF_FFFF;
        send_query(1'b0);
        run_search(lat, bcnt, aok);
        n_checks++;
        if (bcnt !== 24) begin n_fail++; $display("FAIL tie_busy_cycles: got %0d, required 24", bcnt); end
        n_checks++;
        if (pred_class !== 3'd0 || min_dist !== 8'd192) begin
            n_fail++; $display("FAIL tie_result: got %0d/%0d, required 0/192", pred_class, min_dist);
        end
        consume(0, qr, rv);
    endtask

    task automatic randomize_rom(input bit sparse);
        for (int f = 0; f < NF; f++) qry[f] = {$urandom, $urandom};
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++) begin
                logic [W-1:0] m = '0;
                repeat ($urandom_range(0, 3)) m[$urandom_range(0, W - 1)] = 1'b1;
                rom[c][f] = sparse ? (qry[f] ^ m) : {$urandom, $urandom};
            end
    endtask

    task automatic test_backpressure();
        int lat, bcnt, ec, ed;
        bit aok, held;
        logic qr, rv;
        logic [2:0] p0;
        logic [7:0] d0;
        randomize_rom(1'b1);
        ref_search(ec, ed);
        send_query(1'b0);
        run_search(lat, bcnt, aok);
        p0 = pred_class;
        d0 = min_dist;
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!result_valid || pred_class !== p0 || min_dist !== d0 || q_ready) held = 1'b0;
        end
        n_checks++;
        if (p0 !== 3'(ec) || d0 !== 8'(ed)) begin
            n_fail++; $display("FAIL bp_result: got %0d/%0d, required %0d/%0d", p0, d0, ec, ed);
        end
        n_checks++;
        if (!held) begin n_fail++; $display("FAIL bp_hold: got unstable output, required held for 10 cycles"); end
        consume(0, qr, rv);
        n_checks++;
        if (qr !== 1'b1 || rv !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got q_ready=%0b valid=%0b, required 1/0", qr, rv);
        end
        randomize_rom(1'b0);
        ref_search(ec, ed);
        send_query(1'b0);
        run_search(lat, bcnt, aok);
        n_checks++;
        if (pred_class !== 3'(ec) || min_dist !== 8'(ed)) begin
            n_fail++; $display("FAIL bp_second: got %0d/%0d, required %0d/%0d", pred_class, min_dist, ec, ed);
        end
        consume(0, qr, rv);
    endtask

    task automatic test_hold_valid();
        int lat, bcnt, ec, ed;
        bit aok;
        logic qr, rv;
        randomize_rom(1'b1);
        ref_search(ec, ed);
        send_query(1'b1);
        run_search(lat, bcnt, aok);
        n_checks++;
        if (!aok || lat !== 24) begin
            n_fail++; $display("FAIL hold_sweep: got ok=%0b lat=%0d, required 1/24", aok, lat);
        end
        n_checks++;
        if (pred_class !== 3'(ec) || min_dist !== 8'(ed)) begin
            n_fail++; $display("FAIL hold_result: got %0d/%0d, required %0d/%0d", pred_class, min_dist, ec, ed);
        end
        consume(2, qr, rv);
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, ec, ed;
        bit aok;
        logic qr, rv;
        randomize_rom(1'b0);
        send_query(1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({q_ready, result_valid, busy, frame_id, frame_index, pred_class, min_dist} !== {3'b100, 16'd0}) begin
            n_fail++; $display("FAIL mid_search_reset: got rdy=%0b bsy=%0b id=%0d dist=%0d, required 1/0/0/0",
                               q_ready, busy, frame_id, min_dist);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q_valid = 1'b1;
        q_data = {$urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        q_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({q_ready, result_valid, busy, frame_id, frame_index, pred_class, min_dist} !== {3'b100, 16'd0}) begin
            n_fail++; $display("FAIL mid_load_reset: got rdy=%0b valid=%0b bsy=%0b, required 1/0/0",
                               q_ready, result_valid, busy);
        end
        randomize_rom(1'b1);
        ref_search(ec, ed);
        send_query(1'b0);
        run_search(lat, bcnt, aok);
        n_checks++;
        if (lat !== 24 || pred_class !== 3'(ec) || min_dist !== 8'(ed)) begin
            n_fail++; $display("FAIL reset_fresh: got lat=%0d %0d/%0d, required 24 %0d/%0d",
                               lat, pred_class, min_dist, ec, ed);
        end
        consume(0, qr, rv);
    endtask

    task automatic test_random();
        int lat, bcnt, ec, ed;
        bit aok;
        logic qr, rv;
        for (int it = 0; it < 20; it++) begin
            randomize_rom(it % 4 != 0);
            ref_search(ec, ed);
            send_query(1'b0);
            run_search(lat, bcnt, aok);
            n_checks++;
            if (pred_class !== 3'(ec) || min_dist !== 8'(ed)) begin
                n_fail++; $display("FAIL random_%0d: got %0d/%0d, required %0d/%0d",
                                   it, pred_class, min_dist, ec, ed);
            end
            consume($urandom_range(0, 3), qr, rv);
            n_checks++;
            if (qr !== 1'b1 || rv !== 1'b0) begin
                n_fail++; $display("FAIL random_consume_%0d: got %0b/%0b, required 1/0", it, qr, rv);
            end
        end
    endtask

    initial begin
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++) rom[c][f] = '0;
        test_reset();
        test_zero_class();
        test_unique_match();
        test_tie();
        test_backpressure();
        test_hold_valid();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
